// File: rtl/display_pkg.sv
// Shared constants and scan-state encoding for the seven-segment display scan controller.
package display_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/bcd_to_7_seg.sv
// Hex code to active-low seven-segment cathode pattern {g..a} for a common-anode display.
module bcd_to_7_seg
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Full hexadecimal glyph table, 0-9 then A b C d E F
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with guard time and tear-free shadow/active digit buffers.
// Optional per-digit blinking is compiled in with DISPLAY_BLINK_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int NUM_DIGITS   = 4,
    parameter int GUARD_CYC    = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int SLOT_CYC  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int DRIVE_CYC = SLOT_CYC - GUARD_CYC;
    localparam int CNT_W     = $clog2(SLOT_CYC + 1);
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int DW        = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    if (SLOT_CYC < GUARD_CYC + 2) begin : g_bad_slot
        $error("display_scan_ctrl: slot length must exceed guard time by at least 2 cycles");
    end
    if (GUARD_CYC < 1 || NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("display_scan_ctrl: unsupported GUARD_CYC/NUM_DIGITS/BLINK_FRAMES");
    end

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [DW-1:0]           sh_digits_q, sh_digits_d, act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                    sh_valid_q, sh_valid_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_end_s;
    logic                    hide_s;
    logic [3:0]              code_s;
    logic [6:0]              dec_seg_s;

`ifdef DISPLAY_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] BLINK_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                    phase_on_q, phase_on_d;

    // Blink phase: flips every BLINK_FRAMES frame ends, starting in the lit phase
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_on_d  = phase_on_q;
        sh_blink_d  = load ? blink_in : sh_blink_q;
        act_blink_d = (frame_end_s && sh_valid_q) ? sh_blink_q : act_blink_q;
        if (frame_end_s) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = {FC_W{1'b0}};
                phase_on_d  = ~phase_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Blink state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= {FC_W{1'b0}};
            phase_on_q  <= 1'b1;
            sh_blink_q  <= {NUM_DIGITS{1'b0}};
            act_blink_q <= {NUM_DIGITS{1'b0}};
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_on_q  <= phase_on_d;
            sh_blink_q  <= sh_blink_d;
            act_blink_q <= act_blink_d;
        end
    end

    assign hide_s = act_blank_q[digit_q] | (~phase_on_q & act_blink_q[digit_q]);
`else
    assign hide_s = act_blank_q[digit_q];
`endif

    assign code_s      = act_digits_q[{digit_q, 2'b00} +: 4];
    assign frame_end_s = (state_q == DRIVE) && (cnt_q == DRIVE_LAST) && (digit_q == DIGIT_LAST);

    bcd_to_7_seg u_dec (
        .code (code_s),
        .seg  (dec_seg_s)
    );

    // Slot sequencing: GUARD then DRIVE for each digit, wrapping the digit index per frame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        case (state_q)
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = GUARD;
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = GUARD;
                    cnt_d   = {CNT_W{1'b0}};
                    digit_d = (digit_q == DIGIT_LAST) ? {IDX_W{1'b0}} : digit_q + IDX_W'(1);
                end else begin
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = {CNT_W{1'b0}};
                digit_d = {IDX_W{1'b0}};
            end
        endcase
    end

    // Shadow capture and frame-end transfer; the transfer reads pre-edge shadow so a coincident load waits a frame
    always_comb begin
        sh_digits_d  = sh_digits_q;
        sh_blank_d   = sh_blank_q;
        sh_dp_d      = sh_dp_q;
        sh_valid_d   = sh_valid_q;
        act_digits_d = act_digits_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        load_ack_d   = 1'b0;
        frame_done_d = frame_end_s;
        if (frame_end_s && sh_valid_q) begin
            act_digits_d = sh_digits_q;
            act_blank_d  = sh_blank_q;
            act_dp_d     = sh_dp_q;
            load_ack_d   = 1'b1;
            sh_valid_d   = 1'b0;
        end else begin
            load_ack_d   = 1'b0;
        end
        if (load) begin
            sh_digits_d = digits_in;
            sh_blank_d  = blank_in;
            sh_dp_d     = dp_in;
            sh_valid_d  = 1'b1;
        end else begin
            sh_digits_d = sh_digits_q;
        end
    end

    // Pin values for the current slot; dark during guard time or when the digit is hidden
    always_comb begin
        an_d  = {NUM_DIGITS{1'b1}};
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if ((state_q == DRIVE) && !hide_s) begin
            an_d[digit_q] = 1'b0;
            seg_d         = dec_seg_s;
            dp_d          = ~act_dp_q[digit_q];
        end else begin
            dp_d          = 1'b1;
        end
    end

    // State, buffers and registered pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= GUARD;
            cnt_q        <= {CNT_W{1'b0}};
            digit_q      <= {IDX_W{1'b0}};
            sh_digits_q  <= {DW{1'b0}};
            sh_blank_q   <= {NUM_DIGITS{1'b0}};
            sh_dp_q      <= {NUM_DIGITS{1'b0}};
            sh_valid_q   <= 1'b0;
            act_digits_q <= {DW{1'b0}};
            act_blank_q  <= {NUM_DIGITS{1'b1}};
            act_dp_q     <= {NUM_DIGITS{1'b0}};
            an_q         <= {NUM_DIGITS{1'b1}};
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            sh_digits_q  <= sh_digits_d;
            sh_blank_q   <= sh_blank_d;
            sh_dp_q      <= sh_dp_d;
            sh_valid_q   <= sh_valid_d;
            act_digits_q <= act_digits_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus randomized bench for display_scan_ctrl against a cycle-position reference model.
module tb_display_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 4;
    localparam int FRAME = 16;
    localparam int BF    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   digits_in = 16'h0000;
    logic [3:0]    blank_in = 4'h0;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    blink_in = 4'h0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;
    logic          load_ack;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [15:0] m_act_dg, m_sh_dg;
    logic [3:0]  m_act_bl, m_sh_bl, m_act_dp, m_sh_dp, m_act_bk, m_sh_bk;
    bit          m_sv;
    int          m_c;
    int          m_fr;
    int          ack_seen = 0;
    logic [6:0]  seg_on [16];

    display_scan_ctrl #(
        .CLK_HZ       (64),
        .REFRESH_HZ   (4),
        .NUM_DIGITS   (ND),
        .GUARD_CYC    (1),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
`ifdef DISPLAY_BLINK_EN
        .blink_in   (blink_in),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act_dg = 16'h0000; m_act_bl = 4'hF; m_act_dp = 4'h0; m_act_bk = 4'h0;
        m_sh_dg  = 16'h0000; m_sh_bl  = 4'h0; m_sh_dp  = 4'h0; m_sh_bk  = 4'h0;
        m_sv = 1'b0;
        m_c  = 0;
        m_fr = 0;
    endtask

    // One clock: drive inputs, predict pins from frame position, compare, then advance the model
    task automatic step(input bit ld, input logic [15:0] dg, input logic [3:0] bl,
                        input logic [3:0] dpv, input logic [3:0] bk);
        int  pos, d;
        bit  guard, hide, fend, phase_on;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        load = ld; digits_in = dg; blank_in = bl; dp_in = dpv; blink_in = bk;
        pos   = m_c % FRAME;
        d     = pos / SLOT;
        guard = (pos % SLOT) == 0;
        fend  = (pos == FRAME - 1);
        phase_on = ((m_fr / BF) % 2) == 0;
        hide  = m_act_bl[d];
`ifdef DISPLAY_BLINK_EN
        hide  = hide | (!phase_on && m_act_bk[d]);
`endif
        if (guard || hide) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = ~(4'h1 << d);
            e_seg = ~seg_on[m_act_dg[4*d +: 4]];
            e_dp  = ~m_act_dp[d];
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(fend));
        chk("load_ack", 32'(load_ack), 32'(fend && m_sv));
        if (load_ack === 1'b1) ack_seen++;
        if (fend) begin
            if (m_sv) begin
                m_act_dg = m_sh_dg; m_act_bl = m_sh_bl; m_act_dp = m_sh_dp; m_act_bk = m_sh_bk;
                m_sv = 1'b0;
            end
            m_fr++;
        end
        if (ld) begin
            m_sh_dg = dg; m_sh_bl = bl; m_sh_dp = dpv; m_sh_bk = bk; m_sv = 1'b1;
        end
        m_c++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 4'h0, 4'h0, 4'h0);
    endtask

    // Idle until the next step sees the given frame position
    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME && (m_c % FRAME) != pos; i++) idle(1);
    endtask

    initial begin
        int acks0;
        int seg_d0;
        seg_on = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_load_ack", 32'(load_ack), 32'h0);
        reset = 1'b0;

        // Dark for three frames with frame_done every 16 cycles
        idle(3 * FRAME);

        // Load 4321 mid-frame; shown from the next frame
        idle(5);
        step(1'b1, 16'h4321, 4'h0, 4'h0, 4'h0);
        idle_to(1);
        idle(1);
        seg_d0 = 32'(seg);
        chk("digit0_glyph_1", 32'(seg_d0), 32'h79);
        chk("digit0_anode", 32'(an), 32'hE);
        idle(FRAME);

        // Two loads in one frame: one ack, last writer wins
        idle_to(2);
        acks0 = ack_seen;
        step(1'b1, 16'h1111, 4'h0, 4'h5, 4'h0);
        idle(3);
        step(1'b1, 16'h2222, 4'h0, 4'hA, 4'h0);
        idle(2 * FRAME);
        chk("double_load_acks", 32'(ack_seen - acks0), 32'd1);

        // Load on the frame-end edge with shadow empty
        idle_to(FRAME - 1);
        step(1'b1, 16'h5555, 4'h0, 4'h0, 4'h0);
        idle(2 * FRAME);

        // Load on the frame-end edge with a pending shadow
        idle_to(4);
        step(1'b1, 16'h7777, 4'h2, 4'h1, 4'h0);
        idle_to(FRAME - 1);
        step(1'b1, 16'h89AB, 4'h0, 4'hF, 4'h0);
        idle(2 * FRAME);

        // Random loads
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(7) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            else
                idle(1);
        end
        idle(2 * FRAME);

        // Asynchronous reset in the middle of digit 2 drive
        idle_to(10);
        chk("pre_reset_pos", 32'(m_c % FRAME), 32'd10);
        reset = 1'b1;
        #2;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle(2 * FRAME);

`ifdef DISPLAY_BLINK_EN
        // Digit 0 blinks: lit BF frames, dark BF frames
        step(1'b1, 16'h8888, 4'h0, 4'h0, 4'h1);
        idle(8 * FRAME);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
